// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// N-master byte-wide bus arbiter in front of a synchronous single-port RAM
// (1-cycle read latency) and the HCI IO window. The arbiter grants one request
// per cycle in round-robin order, decodes the target region and issues the
// access in the same cycle. It also tracks the single outstanding read and
// routes the returned byte back to its issuer with a registered valid strobe.
//
// Optional build macro:
//   MEM_ARB_LOCK_EN - a granted master holding m_lock keeps the bus for up to
//                     LOCK_MAX consecutive grants. Without it, m_lock is
//                     ignored and arbitration is pure round-robin.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   rdy_in               global enable; low pauses the bus (HCI owns the RAM)
//   m_req/m_wr/m_lock    per-master request, write flag, hold-grant request
//   m_addr/m_wdata       packed per-master address and write data
//   m_gnt                one-hot combinational grant
//   m_rvalid/m_rdata     registered one-hot read valid and shared read data
//   ram_we/ram_addr/ram_din/ram_dout   RAM port
//   io_en/io_sel/io_wr/io_din/io_dout  IO window port
//   io_full              IO output buffer full; IO writes are held off
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int DATA_WIDTH     = 8,
  parameter int IO_SEL_WIDTH   = 3,
  parameter int LOCK_MAX       = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rdy_in,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_wr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]            m_lock,
  output logic [NUM_MASTERS-1:0]            m_gnt,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              ram_we,
  output logic [RAM_ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]             ram_din,
  input  logic [DATA_WIDTH-1:0]             ram_dout,
  output logic                              io_en,
  output logic [IO_SEL_WIDTH-1:0]           io_sel,
  output logic                              io_wr,
  output logic [DATA_WIDTH-1:0]             io_din,
  input  logic [DATA_WIDTH-1:0]             io_dout,
  input  logic                              io_full
);

  // Pointer is kept at least one bit wide so a single-master build elaborates;
  // in that case it can only ever hold 0.
  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             rd_valid_q, rd_valid_d;
  logic [PTR_W-1:0] rd_id_q, rd_id_d;
  logic             rd_io_q, rd_io_d;

`ifdef MEM_ARB_LOCK_EN
  localparam int LOCK_CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  logic [LOCK_CW-1:0] lock_cnt_q, lock_cnt_d;
  logic [LOCK_CW-1:0] cnt_base;
`endif

  logic [NUM_MASTERS-1:0] io_reg;
  logic [NUM_MASTERS-1:0] elig;
  logic                   found;
  logic [PTR_W-1:0]       gnt_idx;
  logic [PTR_W-1:0]       ptr_inc;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic                   sel_wr;
  logic                   sel_io;
  int                     idx;

  // Region decode and eligibility. rst_n is folded in so nothing is granted
  // (and no strobe fires) while the block is held in reset.
  always_comb begin
    io_reg = '0;
    elig   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      io_reg[i] = (m_addr[i*ADDR_WIDTH + RAM_ADDR_WIDTH - 1 +: 2] == 2'b11);
      elig[i]   = m_req[i] && rdy_in && rst_n && !(m_wr[i] && io_reg[i] && io_full);
    end
  end

  // Round-robin search starting at rr_ptr with wrap. With no winner gnt_idx
  // stays 0, so the address/data outputs follow master 0.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && elig[idx]) begin
        found   = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    m_gnt = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_gnt[i] = found && (gnt_idx == PTR_W'(i));
    end
  end

  // Selected master's fields
  always_comb begin
    sel_addr  = m_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = m_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_wr    = m_wr[gnt_idx];
    sel_io    = io_reg[gnt_idx];
  end

  // Access issue, same cycle as the grant
  always_comb begin
    ram_addr = sel_addr[RAM_ADDR_WIDTH-1:0];
    ram_din  = sel_wdata;
    ram_we   = found && sel_wr && !sel_io;
    io_sel   = sel_addr[IO_SEL_WIDTH-1:0];
    io_din   = sel_wdata;
    io_en    = found && sel_io;
    io_wr    = found && sel_io && sel_wr;
  end

  // Pointer / lock update
  always_comb begin
    ptr_inc  = (int'(gnt_idx) == NUM_MASTERS - 1) ? '0 : gnt_idx + 1'b1;
    rr_ptr_d = rr_ptr_q;
`ifdef MEM_ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
    // The pointer parks on a locking master, so a winner that is not the
    // pointer is a different master and starts counting from zero.
    cnt_base   = (gnt_idx == rr_ptr_q) ? lock_cnt_q : '0;
    if (found) begin
      if (m_lock[gnt_idx] && (cnt_base != LOCK_CW'(LOCK_MAX - 1))) begin
        rr_ptr_d   = gnt_idx;
        lock_cnt_d = cnt_base + 1'b1;
      end else begin
        rr_ptr_d   = ptr_inc;
        lock_cnt_d = '0;
      end
    end
`else
    if (found) rr_ptr_d = ptr_inc;
`endif
  end

  // Outstanding-read tracking
  always_comb begin
    rd_valid_d = found && !sel_wr;
    rd_id_d    = rd_id_q;
    rd_io_d    = rd_io_q;
    if (found && !sel_wr) begin
      rd_id_d = gnt_idx;
      rd_io_d = sel_io;
    end
  end

  always_comb begin
    m_rvalid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_rvalid[i] = rd_valid_q && (rd_id_q == PTR_W'(i));
    end
    m_rdata = rd_io_q ? io_dout : ram_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
      rd_io_q    <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      rd_io_q    <= rd_io_d;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_cnt_q <= '0;
    else        lock_cnt_q <= lock_cnt_d;
  end

  logic unused_addr_hi;
  assign unused_addr_hi = ^sel_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^{sel_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH], m_lock};
`endif

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised N-master byte-wide memory/IO bus arbiter between requesters (CPU ports, DMA, debug) and shared targets.
- Targets: one synchronous single-port RAM (1-cycle read latency) and the HCI IO window.
- Per cycle: grants one request round-robin and decodes RAM vs IO region.
- Tracks the outstanding read and steers returned data to the issuing master with a registered valid strobe.

Parameters:
NUM_MASTERS, 2, number of requesting masters (1..8)
ADDR_WIDTH, 32, master address width
RAM_ADDR_WIDTH, 17, RAM address width; IO window = addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11
DATA_WIDTH, 8, data width
IO_SEL_WIDTH, 3, IO register select width (low address bits)
LOCK_MAX, 4, max consecutive grants to a locking master (MEM_ARB_LOCK_EN only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rdy_in  in  1  global enable; low = bus paused (HCI owns RAM)
m_req  in  NUM_MASTERS  per-master request
m_wr  in  NUM_MASTERS  per-master write (1) / read (0)
m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_wdata  in  NUM_MASTERS*DATA_WIDTH  packed write data
m_lock  in  NUM_MASTERS  hold-grant request (used only with MEM_ARB_LOCK_EN)
m_gnt  out  NUM_MASTERS  one-hot combinational grant, same cycle as request
m_rvalid  out  NUM_MASTERS  registered one-hot read-data valid
m_rdata  out  DATA_WIDTH  read data, valid when any m_rvalid bit high
ram_we  out  1  RAM write enable
ram_addr  out  RAM_ADDR_WIDTH  RAM address
ram_din  out  DATA_WIDTH  RAM write data
ram_dout  in  DATA_WIDTH  RAM read data (one cycle after address)
io_en  out  1  IO access strobe
io_sel  out  IO_SEL_WIDTH  IO register select
io_wr  out  1  IO write
io_din  out  DATA_WIDTH  IO write data
io_dout  in  DATA_WIDTH  IO read data (one cycle after io_en)
io_full  in  1  IO output buffer full

Behaviour:
- Reset (rst_n low, async): rr_ptr=0, rd_valid_q=0, rd_id_q=0, rd_io_q=0, lock_cnt=0. m_rvalid=0, m_gnt=0, ram_we=0, io_en=0, io_wr=0 while rst_n low. ram_addr/io_sel/din outputs are don't-care but driven from master 0.
- Eligibility: master i eligible iff m_req[i] && rdy_in && !(m_wr[i] && io_region(i) && io_full). An IO write during io_full is skipped; other masters are still served.
- Arbitration: search eligible masters from rr_ptr upward with wrap; first hit = winner g, m_gnt[g]=1. On grant, rr_ptr <= (g+1) mod NUM_MASTERS. No grant: rr_ptr holds.
- Issue (same cycle as grant):
  - RAM region: ram_addr=m_addr[g][RAM_ADDR_WIDTH-1:0], ram_we=m_wr[g], ram_din=m_wdata[g].
  - IO region: io_en=1, io_wr=m_wr[g], io_sel=m_addr[g][IO_SEL_WIDTH-1:0], io_din=m_wdata[g], ram_we=0.
  - ram_we=0 and io_en=0 when there is no grant.
- Read return, 1-cycle latency: on a read grant, rd_valid_q<=1, rd_id_q<=g, rd_io_q<=io_region; otherwise rd_valid_q<=0.
  - m_rvalid[rd_id_q]=rd_valid_q.
  - m_rdata = rd_io_q ? io_dout : ram_dout.
  - Writes never raise m_rvalid.
- Back-to-back: a new grant is allowed in the cycle a previous read returns (fully pipelined, 1 access/cycle).
- rdy_in low: no grants, pointer/lock frozen. A read already registered still returns the next cycle (rvalid asserted irrespective of rdy_in).
- Masters hold req/addr/wr/wdata stable until granted. Deasserting m_req before grant is legal, with no side effect.
- Single master (NUM_MASTERS=1): rr_ptr is constant 0.
- Address bits above RAM_ADDR_WIDTH are ignored.

Optional Feature:
MEM_ARB_LOCK_EN
- Defined:
  - If winner g has m_lock[g]=1, rr_ptr stays at g and lock_cnt increments, so g wins again next cycle while eligible.
  - When lock_cnt reaches LOCK_MAX-1 on a grant, rr_ptr advances normally and lock_cnt clears.
  - lock_cnt also clears on any grant without lock or to a different master.
  - rdy_in low freezes lock_cnt.
- Undefined: m_lock ignored, lock_cnt absent, pure round-robin.

Test Plan:
- Reset mid-read: grant read at addr 0x10, drop rst_n next cycle -> m_rvalid=0, m_gnt=0; after release rr_ptr=0, so with both masters requesting, master 0 is granted first.
- Contention: M0 and M1 read RAM 0x100/0x200 continuously, RAM preloaded 0xAA/0xBB -> grants alternate 0,1,0,1. m_rvalid alternates one cycle later with m_rdata 0xAA,0xBB.
- IO routing: M1 reads 0x30004, io_dout=0x5C, ram_dout=0x11 -> io_en=1, io_sel=4, ram_we=0; next cycle m_rvalid[1]=1, m_rdata=0x5C.
- io_full skip: io_full=1, M0 writes 0x30000 data 0x41, M1 writes RAM 0x8 data 0x77 -> only M1 granted (ram_we=1, ram_din=0x77). io_full drops -> M0 granted, io_wr=1, io_din=0x41.
- Pause: read granted at cycle t, rdy_in=0 at t+1 -> m_rvalid still pulses at t+1; no grants and ram_we=0 while rdy_in=0; rr_ptr unchanged on resume.
- MEM_ARB_LOCK_EN, LOCK_MAX=4: M0 with m_lock=1 and M1 both requesting -> M0 granted 4 consecutive cycles, then M1. Without the macro -> strict alternation.
